// File: rtl/data_mem_lsu.sv
// Multi-cycle load/store unit with an internal word-organised data array and programmable wait states.
// Optional byte lane support is compiled in when LSU_BYTE_EN is defined.
module data_mem_lsu #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        MemWrite,
    input  logic        ByteEn,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        Fault
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
    localparam logic [2:0]  WAIT_CNT = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   addrReg;
    logic [31:0]     dataReg;
    logic            writeReg;
    logic [2:0]      countReg;
    logic [31:0]     mem [DEPTH];

    logic            inRange;
    logic            aligned;
    logic            legal;
    logic            accessNow;
    logic [3:0]      laneWe;
    logic [31:0]     laneData;
    logic [31:0]     memWord;
    logic [31:0]     loadData;

`ifdef LSU_BYTE_EN
    logic            byteReg;
    logic [1:0]      laneReg;
`else
    logic            unusedByteEn;
    assign unusedByteEn = ByteEn;
`endif

    assign accessNow = (state == BUSY) && (countReg == 3'd0);
    assign memWord   = mem[addrReg];

    // Address legality: any nonzero upper word-index bit lands out of range
    always_comb begin
        inRange = ({2'b00, ALUResult[31:2]} < DEPTH_W);
`ifdef LSU_BYTE_EN
        aligned = ByteEn || (ALUResult[1:0] == 2'b00);
`else
        aligned = (ALUResult[1:0] == 2'b00);
`endif
        legal = inRange && aligned;
    end

    // Store lane enables and write data, plus load result formatting
    always_comb begin
        laneWe   = 4'b0000;
        laneData = dataReg;
        loadData = memWord;
        if (accessNow && writeReg) begin
`ifdef LSU_BYTE_EN
            if (byteReg) begin
                laneWe   = 4'b0001 << laneReg;
                laneData = {4{dataReg[7:0]}};
            end else begin
                laneWe   = 4'b1111;
            end
`else
            laneWe = 4'b1111;
`endif
        end else begin
            laneWe = 4'b0000;
        end
`ifdef LSU_BYTE_EN
        if (byteReg) begin
            loadData = {24'h000000, memWord[8*laneReg +: 8]};
        end else begin
            loadData = memWord;
        end
`endif
    end

    // Stall drops in DONE so the processor advances on the completing edge
    assign Stall = reset && (((state == IDLE) && req) || (state == BUSY));

    // Data array: no reset, written only on the edge that leaves BUSY
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (laneWe[i]) begin
                mem[addrReg][8*i +: 8] <= laneData[8*i +: 8];
            end
        end
    end

    // Access sequencing FSM with registered Done/Fault/ReadData
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addrReg  <= '0;
            dataReg  <= 32'h00000000;
            writeReg <= 1'b0;
            countReg <= 3'd0;
            ReadData <= 32'h00000000;
            Done     <= 1'b0;
            Fault    <= 1'b0;
`ifdef LSU_BYTE_EN
            byteReg  <= 1'b0;
            laneReg  <= 2'b00;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && legal) begin
                        addrReg  <= ALUResult[AW+1:2];
                        dataReg  <= WriteData;
                        writeReg <= MemWrite;
                        countReg <= WAIT_CNT;
`ifdef LSU_BYTE_EN
                        byteReg  <= ByteEn;
                        laneReg  <= ALUResult[1:0];
`endif
                        state    <= BUSY;
                    end else if (req) begin
                        Fault    <= 1'b1;
                        ReadData <= 32'h00000000;
                        Done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state    <= IDLE;
                    end
                end
                BUSY: begin
                    if (countReg != 3'd0) begin
                        countReg <= countReg - 3'd1;
                    end else begin
                        if (!writeReg) begin
                            ReadData <= loadData;
                        end
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store unit and data memory that sits directly downstream of the processor datapath. It consumes the datapath's `ALUResult` (address) and `WriteData`, and returns `ReadData` for the `MemtoReg` writeback path. Accesses are multi-cycle with a programmable wait-state count. While an access is in flight, `Stall` freezes the PC and register-file writes, and `Done` marks the completing cycle.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words in the internal data array; valid byte addresses are 0 to 4*DEPTH-1.
- `WAIT_CYCLES`, 2: number of extra wait states per access; range 0–7.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request; equals MemWrite | MemtoReg from control.
- `MemWrite`  in  1  1 = store, 0 = load; sampled together with `req`.
- `ByteEn`  in  1  byte access (LDRB/STRB); honoured only with `LSU_BYTE_EN`.
- `ALUResult`  in  32  byte address.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  load result; valid in the `Done` cycle, then held.
- `Stall`  out  1  processor must hold PC and suppress RegWrite.
- `Done`  out  1  one-cycle pulse in the completing cycle.
- `Fault`  out  1  sticky alignment or range error.

## Operation
- States:
  - IDLE:
    - If `req`=1 and the address is legal: latch address, data, `MemWrite` and `ByteEn`; load the counter with `WAIT_CYCLES`; go to BUSY.
    - If `req`=1 and the address is illegal: set `Fault` and go to DONE. No array access occurs, and `ReadData` is set to 0.
  - BUSY:
    - While counter ≠ 0: decrement the counter.
    - When counter = 0: perform the access (store writes the array; load registers `ReadData`), then go to DONE.
  - DONE: `Done`=1; unconditionally go to IDLE. `req` is ignored in this cycle because it belongs to the completing instruction.
- `Stall` = (IDLE & `req`) | BUSY. It is combinational and is 0 in DONE, so the processor advances on the `Done` edge.
- Illegal address:
  - word address ≥ DEPTH; or
  - `ALUResult[1:0]` ≠ 0 on a word access.
- Byte access (macro on):
  - Little-endian lane select `ALUResult[1:0]`.
  - Load zero-extends the selected byte into `ReadData[7:0]`.
  - Store replaces only the selected lane with `WriteData[7:0]`.
- Address register is word index `ALUResult[31:2]`. Upper bits that are nonzero count as out of range.
- The array has no reset and power-up contents are undefined. The bench writes before it reads.

## Timing
- Reset values: `ReadData`=0, `Stall`=0, `Done`=0, `Fault`=0, state IDLE, counter 0.
- Latency: `req` first seen in cycle 0 gives `Done` in cycle WAIT_CYCLES+2, and `Stall` is high for WAIT_CYCLES+2 cycles.
- Fault path: `Stall` is high for 1 cycle and `Done` pulses in cycle 1.
- Store array update occurs on the edge that leaves BUSY. A read of the same word at any later access returns the new data.
- `req` held high continuously (back-to-back memory instructions): the next access starts in the IDLE cycle after DONE.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs zero.
  - A store not yet performed (still counting in BUSY) is aborted, and the array is unchanged.
- `Fault` remains set until reset. Later legal accesses still complete normally.

## Configuration
- `LSU_BYTE_EN` defined: `ByteEn` is honoured and byte loads and stores operate as above. Byte accesses are never misaligned.
- `LSU_BYTE_EN` undefined:
  - `ByteEn` is ignored and all accesses are word accesses.
  - `ALUResult[1:0]` ≠ 0 raises `Fault`.
  - Lane-select logic is not compiled.

## Test plan
1. WAIT_CYCLES=2: store 0x12345678 to 0x8, then load 0x8 → `Stall` high 4 cycles each, `Done` in cycle 4, `ReadData`=0x12345678.
2. Macro on, 0x8 holding 0x12345678: STRB 0xAB at 0x9 → word load of 0x8 returns 0x1234AB78; LDRB of 0xA returns 0x00000034.
3. Word load at 0x6 (macro off, or ByteEn=0) → `Fault`=1 after 1 cycle, `Done` in cycle 1, `ReadData`=0, array unchanged.
4. Store 0xDEADBEEF to 0x100 with DEPTH=64 → `Fault`=1, no write; a later load of 0x0 returns its prior value.
5. 0x10 preloaded with 0x55; start a store of 0xFF to 0x10, drop `reset` in BUSY with counter=1 → outputs 0 immediately; after release, load of 0x10 returns 0x55.
6. `req` held high for store 0x4 followed by load 0x4, WAIT_CYCLES=0 → `Done` pulses at cycles 2 and 5, second `ReadData` equals the stored value.
